fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of the IF/EX pipeline register. It owns the fetch PC and issues word fetches to a fixed 1-cycle-latency instruction memory. Returned instructions are buffered with their PCs in a small queue, and the unit presents them to decode over a valid/ready handshake. A redirect (taken branch or jump) flushes all queued and in-flight fetches and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FQ_DEPTH, 2, fetch queue entries; power of 2, at least 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  flush and restart fetch this cycle
redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
imem_req  out  1  fetch request; always accepted by imem
imem_addr  out  32  word-aligned fetch address
imem_rdata  in  32  instruction; valid exactly 1 cycle after an imem_req cycle
if_valid  out  1  queue head valid toward decode
if_ready  in  1  decode accepts head
if_instr  out  32  head instruction; 32'h0000_0013 (NOP) when if_valid=0
if_pc  out  32  head PC
if_pc_plus4  out  32  head PC+4, modulo 2^32

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, queue empty, inflight=0, imem_req=0, if_valid=0, if_instr=NOP, if_pc=0, if_pc_plus4=0. Release takes effect on the next clk edge.
- Credits: pop = if_valid & if_ready. Issue is allowed when (count + inflight - pop) < FQ_DEPTH. Steady state is 1 instruction/cycle with FQ_DEPTH=2.
- Normal issue: imem_req=1, imem_addr=fetch_pc. At the edge, fetch_pc += 4 (wraps modulo 2^32), inflight <= 1, inflight_pc <= fetch_pc.
- Response: in the cycle after an issue, if inflight=1 and not killed, push {inflight_pc, imem_rdata} at the end of that cycle. If no new issue occurs, inflight clears.
- Latency: issue in cycle N gives if_valid in N+2. First if_valid comes 2 cycles after the first post-reset cycle with rst_n=1.
- Redirect priority: it overrides everything in the same cycle.
  - if_valid is forced 0 combinationally, so no pop occurs.
  - Queue is flushed (count=0, pointers reset).
  - In-flight response is killed and is not pushed next cycle.
  - imem_req=1, imem_addr=redirect_pc&~3. fetch_pc <= target+4, inflight <= 1 with new PC.
  - Target instruction appears at if_valid 2 cycles after the redirect cycle.
- Back-to-back redirects: each one kills the previous in-flight fetch; only the last target survives.
- Queue: circular buffer with wrap-around pointers and a count.
  - Push when full cannot occur under the credit rule; it is covered by an assertion.
  - Pop when empty does not occur (if_valid=0).
  - Simultaneous push and pop leaves count unchanged.
- Output fields are driven from the queue head (registered storage) and gated by if_valid.
- Reset mid-operation: state returns immediately to reset values, and in-flight data is discarded.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t {pc[31:0], instr[31:0]}
  - NOP_INSTR = 32'h0000_0013
  - ADDR_ALIGN_MASK = 32'hFFFF_FFFC
- Sub-module fetch_queue: parameterised FIFO of fetch_entry_t, with push/pop/flush, count, empty/full. It is reset to empty asynchronously.

Test Plan:
- Reset release, if_ready=1, imem model returns rdata=addr^32'hA5A5_0000 → imem_addr is 0,4,8,… each cycle. First if_valid occurs 2 cycles after release with if_pc=0; then one instruction per cycle with contiguous PCs and matching instr.
- if_ready=0 for 6 cycles mid-stream → imem_req drops once count+inflight=2, and if_pc holds. On release there are no lost or duplicated PCs (e.g. 0x10,0x14,0x18 continue).
- redirect_valid with redirect_pc=0x0000_0103 while an issue is in flight → same cycle imem_addr=0x100 and if_valid=0. The stale response is dropped. if_valid returns 2 cycles later with if_pc=0x100, if_pc_plus4=0x104.
- Redirect in the same cycle as if_valid&if_ready with 2 entries queued → no pop is counted, and both queued entries never appear. The next output is the target.
- Redirect to 0xFFFF_FFFC → if_pc=0xFFFF_FFFC, if_pc_plus4=0, and the next if_pc=0x0000_0000.
- Assert rst_n=0 asynchronously mid-stream with the queue full → outputs go to reset values before the next edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instr} entries with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pointer and occupancy bookkeeping; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents only matter once counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The upstream credit scheme must never overfill or underflow the queue.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: issues word fetches to a 1-cycle imem, queues the returned
// instructions and hands them to decode; a redirect flushes everything.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   redirect_target;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_wdata;
  logic [CW:0]   occ_after;
  logic          issue_ok;

  assign redirect_target = redirect_pc & ADDR_ALIGN_MASK;

  // A redirect hides the head so nothing stale is consumed in that cycle.
  assign if_valid = ~q_empty & ~redirect_valid;
  assign q_pop    = if_valid & if_ready;
  assign q_push   = inflight & ~redirect_valid;
  assign q_wdata  = '{pc: inflight_pc, instr: imem_rdata};

  // Slots already promised (queued + returning) once this cycle's pop leaves.
  assign occ_after = {1'b0, q_count} + (CW + 1)'(inflight) - (CW + 1)'(q_pop);
  assign issue_ok  = occ_after < (CW + 1)'(FQ_DEPTH);

  // Fetch request: a redirect always issues its target; otherwise credit-limited.
  always_comb begin
    imem_req  = rst_n & (redirect_valid | issue_ok);
    imem_addr = fetch_pc;
    if (redirect_valid) imem_addr = redirect_target;
  end

  // Decode-facing fields come from the queue head and read as a NOP when idle.
  always_comb begin
    if_instr    = NOP_INSTR;
    if_pc       = '0;
    if_pc_plus4 = '0;
    if (if_valid) begin
      if_instr    = q_head.instr;
      if_pc       = q_head.pc;
      if_pc_plus4 = q_head.pc + 32'd4;
    end
  end

  // Fetch PC and the single outstanding-request tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_target + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= redirect_target;
    end else if (issue_ok) begin
      fetch_pc    <= fetch_pc + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // A returning fetch always has a free slot to land in.
  assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC stream kept in a queue,
// monitor compares every consumed instruction and the issue/credit behaviour.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data for a request is visible the following cycle,
  // garbage otherwise so any use of a non-requested cycle shows up.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ KEY;
    else          imem_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: stream scoreboard, credit/issue model, redirect latency, gating.
  logic        prev_rst = 1'b0;
  int          outst    = 0;
  int          pend_age = -1;
  logic [31:0] pend_pc  = '0;
  logic [31:0] nxt_fetch = RST_PC;
  always @(negedge clk) begin
    logic        pop;
    int          new_outst;
    logic [31:0] e;
    if (!rst_n) begin
      outst     = 0;
      pend_age  = -1;
      nxt_fetch = RST_PC;
    end else begin
      pop = if_valid && if_ready;
      if (pend_age >= 0) pend_age++;
      if (pend_age == 2 && !redirect_valid) begin
        check("lat_valid", {31'b0, if_valid}, 32'd1);
        check("lat_pc", if_pc, pend_pc);
        pend_age = -1;
      end
      if (!prev_rst) begin
        pend_age = 0;
        pend_pc  = RST_PC;
      end
      if (redirect_valid) begin
        pend_age = 0;
        pend_pc  = redirect_pc & 32'hFFFF_FFFC;
        check("redir_req", {31'b0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, pend_pc);
        check("redir_hide", {31'b0, if_valid}, 32'd0);
        nxt_fetch = pend_pc + 32'd4;
        new_outst = 1;
      end else begin
        check("issue_req", {31'b0, imem_req}, {31'b0, (outst - int'(pop)) < DEPTH});
        if (imem_req) begin
          check("fetch_addr", imem_addr, nxt_fetch);
          nxt_fetch = nxt_fetch + 32'd4;
        end
        new_outst = outst + int'(imem_req) - int'(pop);
        check("occupancy", {31'b0, new_outst <= DEPTH}, 32'd1);
      end
      if (!if_valid) begin
        check("idle_instr", if_instr, NOP_INSTR);
        check("idle_pc", if_pc | if_pc_plus4, 32'd0);
      end
      if (pop) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc %h expected no output", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e);
          check("if_instr", if_instr, e ^ KEY);
          check("if_pc_plus4", if_pc_plus4, e + 32'd4);
          exp_q.push_back(e + 32'd4);
        end
      end
      outst = new_outst;
    end
    prev_rst = rst_n;
  end

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_q.delete();
    exp_q.push_back(tgt & 32'hFFFF_FFFC);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    check({tag, "_instr"}, if_instr, NOP_INSTR);
    check({tag, "_pc"}, if_pc, 32'd0);
    check({tag, "_pc4"}, if_pc_plus4, 32'd0);
  endtask

  initial begin
    logic [31:0] held_pc;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");

    // Release and streaming start-up latency.
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    @(negedge clk);
    check("start_valid0", {31'b0, if_valid}, 32'd0);
    check("start_addr0", imem_addr, 32'h0);
    @(negedge clk);
    check("start_valid1", {31'b0, if_valid}, 32'd0);
    check("start_addr1", imem_addr, 32'h4);
    @(negedge clk);
    check("start_valid2", {31'b0, if_valid}, 32'd1);
    check("start_pc", if_pc, 32'h0);
    repeat (3) @(negedge clk);
    check("stream_valid", {31'b0, if_valid}, 32'd1);

    // Decode stall: fetch throttles and the head holds.
    @(posedge clk); #1 if_ready = 1'b0;
    @(negedge clk);
    held_pc = if_pc;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_pc_hold", if_pc, held_pc);
    end

    // Redirect while two entries are queued and decode is ready.
    @(posedge clk); #1 if_ready = 1'b1;
    do_redirect(32'h0000_0103);
    @(negedge clk);
    check("rq_addr", imem_addr, 32'h100);
    check("rq_valid", {31'b0, if_valid}, 32'd0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("rq_valid1", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    check("rq_pc", if_pc, 32'h100);
    check("rq_pc4", if_pc_plus4, 32'h104);

    // Redirect with a fetch in flight during steady streaming.
    repeat (3) @(posedge clk);
    #1 do_redirect(32'h0000_0200);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Back-to-back redirects: only the last target survives.
    #1 do_redirect(32'h0000_0300);
    @(posedge clk); #1 do_redirect(32'h0000_0402);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Wrap of the PC at the top of the address space.
    #1 do_redirect(32'hFFFF_FFFE);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_plus4, 32'h0);
    @(negedge clk);
    check("wrap_next", if_pc, 32'h0);

    // Asynchronous reset with the queue full.
    @(posedge clk); #1 if_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    if_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    @(negedge clk);
    check("restart_addr", imem_addr, RST_PC);
    check("restart_req", {31'b0, imem_req}, 32'd1);

    // Randomized traffic: decode backpressure and random redirects.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 7) == 0) do_redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
        else                           do_redirect($urandom);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1 redirect_valid = 1'b0;
    if_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("activity", {31'b0, pops > 500}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
